// File: rtl/btn_cmd_gen.sv
// btn_cmd_gen: front-panel command generator.
// Synchronizes and debounces the Next/Pre/Verify buttons and the Stop switch,
// then issues one-cycle command pulses (one per cycle, priority Next > Pre > Verify)
// and the debounced Stop level. Presses arriving together are queued as pending bits.
// Optional feature: define AUTOREPEAT_EN to let held Next/Pre buttons auto-repeat.
module btn_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic CLK_in,
    input  logic Reset,
    input  logic BtnNext_raw,
    input  logic BtnPre_raw,
    input  logic BtnVerify_raw,
    input  logic SwStop_raw,
    output logic Next,
    output logic Pre,
    output logic Verify,
    output logic Stop
);

    // Channel index: 0 = Next, 1 = Pre, 2 = Verify, 3 = Stop
    localparam int NCH = 4;
    localparam int CW  = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [NCH-1:0] raw_in;
    logic [NCH-1:0] s1_q;
    logic [NCH-1:0] s2_q;
    logic [NCH-1:0] stable_q;
    logic [NCH-1:0] stable_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];

    logic [2:0] press_evt;
    logic [2:0] repeat_evt;
    logic [2:0] pending_q;
    logic [2:0] pending_d;
    logic [2:0] cmd_q;
    logic [2:0] cmd_d;

    assign raw_in = {SwStop_raw, BtnVerify_raw, BtnPre_raw, BtnNext_raw};

    // Debounce: the count runs only while the synchronized input disagrees with
    // the accepted level; any agreement (a bounce back) restarts it from zero.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_deb
        logic          same;
        logic [CW-1:0] cnt_inc;
        logic          hit;

        assign same        = (s2_q[gi] == stable_q[gi]);
        assign cnt_inc     = cnt_q[gi] + CW'(1);
        assign hit         = !same && (cnt_inc == CW'(DEBOUNCE_CYCLES));
        assign cnt_d[gi]   = (same || hit) ? '0 : cnt_inc;
        assign stable_d[gi] = hit ? s2_q[gi] : stable_q[gi];
    end

    // Synchronizer, debounce counter and accepted-level registers
    always_ff @(posedge CLK_in) begin
        if (Reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            s1_q     <= raw_in;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // A press is the accepted level rising; detected on the same edge it is accepted
    assign press_evt = stable_d[2:0] & ~stable_q[2:0];

`ifdef AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

    logic [RW-1:0] rep_q [2];
    logic [RW-1:0] rep_d [2];

    // Repeat timers for Next and Pre. After the first repeat at REPEAT_DELAY the
    // timer folds back to REPEAT_DELAY so later repeats come every REPEAT_PERIOD.
    // A release accepted on the firing edge suppresses that repeat.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rep
        logic [RW-1:0] rep_inc;
        logic          at_first;
        logic          at_period;

        assign rep_inc   = rep_q[gi] + RW'(1);
        assign at_first  = (rep_inc == RW'(REPEAT_DELAY));
        assign at_period = (rep_inc == RW'(REPEAT_DELAY + REPEAT_PERIOD));
        assign repeat_evt[gi] = stable_q[gi] && stable_d[gi] && (at_first || at_period);
        assign rep_d[gi] = !stable_q[gi] ? '0 :
                           at_period     ? RW'(REPEAT_DELAY) : rep_inc;
    end
    assign repeat_evt[2] = 1'b0;

    // Repeat timer registers
    always_ff @(posedge CLK_in) begin
        if (Reset) begin
            for (int i = 0; i < 2; i++) rep_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) rep_q[i] <= rep_d[i];
        end
    end
`else
    assign repeat_evt = 3'b000;
`endif

    // Arbiter: grant the highest-priority pending command, keep the rest queued,
    // and merge in new events (an already-pending bit stays single).
    always_comb begin
        cmd_d = 3'b000;
        if (pending_q[0])      cmd_d = 3'b001;
        else if (pending_q[1]) cmd_d = 3'b010;
        else if (pending_q[2]) cmd_d = 3'b100;
        pending_d = (pending_q & ~cmd_d) | press_evt | repeat_evt;
    end

    // Pending bits and registered command pulses
    always_ff @(posedge CLK_in) begin
        if (Reset) begin
            pending_q <= '0;
            cmd_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cmd_q     <= cmd_d;
        end
    end

    assign Next   = cmd_q[0];
    assign Pre    = cmd_q[1];
    assign Verify = cmd_q[2];
    assign Stop   = stable_q[3];

endmodule

// File: tb/tb_btn_cmd_gen.sv
// Directed testbench for btn_cmd_gen with N=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Edge numbering restarts at 0 after each reset; outputs are checked 1 ns after each edge.
// The auto-repeat scenario runs only when AUTOREPEAT_EN is defined.
module tb_btn_cmd_gen;

    logic CLK_in = 1'b0;
    logic Reset = 1'b1;
    logic BtnNext_raw = 1'b0;
    logic BtnPre_raw = 1'b0;
    logic BtnVerify_raw = 1'b0;
    logic SwStop_raw = 1'b0;
    logic Next, Pre, Verify, Stop;

    int checks = 0;
    int failures = 0;

    btn_cmd_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8)
    ) dut (
        .CLK_in(CLK_in),
        .Reset(Reset),
        .BtnNext_raw(BtnNext_raw),
        .BtnPre_raw(BtnPre_raw),
        .BtnVerify_raw(BtnVerify_raw),
        .SwStop_raw(SwStop_raw),
        .Next(Next),
        .Pre(Pre),
        .Verify(Verify),
        .Stop(Stop)
    );

    always #5 CLK_in = ~CLK_in;

    task automatic chk(input string tag, input string sig, input int e,
                       input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d %s observed=%b expected=%b", tag, e, sig, obs, exp);
        end
    endtask

    // Drive inputs for edge e, clock it, then check all four outputs
    task automatic step(input string tag, input int e,
                        input logic n, input logic p, input logic v, input logic s,
                        input logic r,
                        input logic en, input logic ep, input logic ev, input logic es);
        BtnNext_raw   = n;
        BtnPre_raw    = p;
        BtnVerify_raw = v;
        SwStop_raw    = s;
        Reset         = r;
        @(posedge CLK_in);
        #1;
        chk(tag, "Next", e, Next, en);
        chk(tag, "Pre", e, Pre, ep);
        chk(tag, "Verify", e, Verify, ev);
        chk(tag, "Stop", e, Stop, es);
        $display("%s edge=%0d in=%b%b%b%b rst=%b out N=%b P=%b V=%b S=%b",
                 tag, e, n, p, v, s, r, Next, Pre, Verify, Stop);
    endtask

    // One reset edge with all inputs low; outputs must read back as zero
    task automatic do_reset(input string tag);
        step(tag, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset("reset");

        // Clean Next press held edges 0..29, released afterwards
        do_reset("rst_next");
        for (int e = 0; e < 40; e++) begin
`ifdef AUTOREPEAT_EN
            step("next_held", e, (e <= 29), 1'b0, 1'b0, 1'b0, 1'b0,
                 (e == 6 || e == 26 || e == 34), 1'b0, 1'b0, 1'b0);
`else
            step("next_held", e, (e <= 29), 1'b0, 1'b0, 1'b0, 1'b0,
                 (e == 6), 1'b0, 1'b0, 1'b0);
`endif
        end

        // Pre bounces (high on edges 2,3,6,7) then held from edge 10
        do_reset("rst_pre");
        for (int e = 0; e < 24; e++) begin
            step("pre_bounce", e, 1'b0, (e >= 10) ? 1'b1 : (((e / 2) % 2) == 1), 1'b0, 1'b0,
                 1'b0, 1'b0, (e == 16), 1'b0, 1'b0);
        end

        // Next and Pre rise together: Next first, Pre the following cycle
        do_reset("rst_both");
        for (int e = 0; e < 16; e++) begin
            step("next_pre", e, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                 (e == 6), (e == 7), 1'b0, 1'b0);
        end

`ifdef AUTOREPEAT_EN
        // Pre held edges 0..59: repeats at 26, then every 8; release suppresses 66
        do_reset("rst_rep");
        for (int e = 0; e < 72; e++) begin
            step("pre_repeat", e, 1'b0, (e <= 59), 1'b0, 1'b0, 1'b0,
                 1'b0, (e inside {6, 26, 34, 42, 50, 58}), 1'b0, 1'b0);
        end
`endif

        // Verify held from edge 0, Reset pulsed at edge 3 restarts the debounce
        do_reset("rst_verify");
        for (int e = 0; e < 16; e++) begin
            step("verify_rst", e, 1'b0, 1'b0, 1'b1, 1'b0, (e == 3),
                 1'b0, 1'b0, (e == 10), 1'b0);
        end

        // Stop switch on at edge 0, off at edge 20
        do_reset("rst_stop");
        for (int e = 0; e < 30; e++) begin
            step("stop_level", e, 1'b0, 1'b0, 1'b0, (e < 20), 1'b0,
                 1'b0, 1'b0, 1'b0, (e >= 5 && e < 25));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
